alu_fpga_ctrl: RTL and testbench

- Board-level sequential front end for exercising the ALU on the DE2 board.
- Debounces push-buttons and steps through operand/opcode entry with an FSM: load A, load B, load op, execute, show.
- Drives the ALU ports, latches the result and flags, and renders any register on a parametrised, pageable bank of active-low 7-segment digits.
- The ALU is instantiated outside this block and connected through the alu_* ports.

---
 rtl/alu_fpga_ctrl.sv | 271 +++++++++++++++++++++++++++
 tb/tb_alu_fpga_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_fpga_ctrl.sv
//------------------------------------------------------------------------------
// Module   : alu_fpga_ctrl
// Brief    : Board front end for an external ALU. Debounces three push-buttons,
//            walks an operand/opcode entry FSM (LOAD_A, LOAD_B, LOAD_OP, EXEC,
//            SHOW), drives the ALU ports, latches result and flags, and shows
//            the selected register on a pageable bank of active-low 7-seg
//            digits.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_fpga_ctrl #(
   parameter int DATA_W    = 32,
   parameter int SW_W      = 16,
   parameter int OP_W      = 4,
   parameter int NDIGITS   = 8,
   parameter int DB_CYCLES = 16
) (
   input  logic                   CLOCK_50,
   input  logic                   RST,
   input  logic [SW_W-1:0]        sw_data,
   input  logic                   sw_fill,
   input  logic [2:0]             key_n,
   output logic [DATA_W-1:0]      alu_port_a,
   output logic [DATA_W-1:0]      alu_port_b,
   output logic [OP_W-1:0]        alu_op,
   input  logic [DATA_W-1:0]      alu_port_o,
   input  logic                   alu_negative,
   input  logic                   alu_zero,
   input  logic                   alu_overflow,
   output logic [7*NDIGITS-1:0]   hex_seg,
   output logic [2:0]             led_flags,
   output logic [4:0]             led_state
);

   // Display geometry: one page holds NDIGITS nibbles.
   localparam int c_PG_BITS = 4 * NDIGITS;
   localparam int c_NPAGES  = (DATA_W + c_PG_BITS - 1) / c_PG_BITS;
   localparam int c_PAGE_W  = (c_NPAGES > 1) ? $clog2(c_NPAGES) : 1;
   localparam int c_DISP_W  = c_NPAGES * c_PG_BITS;
   localparam int c_CNT_W   = $clog2(DB_CYCLES + 1);

   // One-hot encoding doubles as the LED pattern.
   typedef enum logic [4:0] {
      S_LOAD_A  = 5'b00001,
      S_LOAD_B  = 5'b00010,
      S_LOAD_OP = 5'b00100,
      S_EXEC    = 5'b01000,
      S_SHOW    = 5'b10000
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [DATA_W-1:0]      r_a, w_a_nxt;
   logic [DATA_W-1:0]      r_b, w_b_nxt;
   logic [OP_W-1:0]        r_op, w_op_nxt;
   logic [DATA_W-1:0]      r_res, w_res_nxt;
   logic [2:0]             r_flags, w_flags_nxt;
   logic [c_PAGE_W-1:0]    r_page, w_page_nxt;

   logic [2:0]             w_press;
   logic                   w_enter;
   logic                   w_back;
   logic                   w_page;
   logic [DATA_W-1:0]      w_operand;
   logic [DATA_W-1:0]      w_disp_src;
   logic [c_DISP_W-1:0]    w_disp_ext;
   logic [c_PG_BITS-1:0]   w_page_vec;
   logic [NDIGITS-1:0]     w_blank;

   // Active-low segment patterns, gfedcba.
   function automatic logic [6:0] f_seg7(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b0000011;
         4'hC:    seg = 7'b0100111;
         4'hD:    seg = 7'b0100001;
         4'hE:    seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
      return seg;
   endfunction

   //---------------------------------------------------------------------------
   // Key conditioning: each key gets its own synchroniser and debouncer. The
   // pulse is registered alongside the level update so it lasts one cycle.
   //---------------------------------------------------------------------------
   for (genvar k = 0; k < 3; k++) begin : g_key
      logic               r_sync1;
      logic               r_sync2;
      logic               r_level;
      logic               r_pulse;
      logic [c_CNT_W-1:0] r_cnt;

      // synchronise, count stable cycles, accept the level and flag presses
      always_ff @(posedge CLOCK_50) begin
         if (RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
         end else begin
            r_sync1 <= key_n[k];
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            if (r_sync2 == r_level) begin
               r_cnt <= '0;
            end else if (r_cnt == c_CNT_W'(DB_CYCLES - 1)) begin
               r_level <= r_sync2;
               r_cnt   <= '0;
               r_pulse <= ~r_sync2;
            end else begin
               r_cnt <= r_cnt + c_CNT_W'(1);
            end
         end
      end

      assign w_press[k] = r_pulse;
   end

   // enter beats back beats page; losers in the same cycle are dropped
   assign w_enter = w_press[0];
   assign w_back  = w_press[1] & ~w_press[0];
   assign w_page  = w_press[2] & ~w_press[1] & ~w_press[0];

   // Switch value widened with the fill bit above the switch field.
   if (DATA_W > SW_W) begin : g_fill
      assign w_operand = {{(DATA_W - SW_W){sw_fill}}, sw_data};
   end else begin : g_nofill
      assign w_operand = sw_data;
   end

   //---------------------------------------------------------------------------
   // Entry FSM
   //---------------------------------------------------------------------------
   // next-state, register updates and page stepping
   always_comb begin
      w_state_nxt = r_state;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_op_nxt    = r_op;
      w_res_nxt   = r_res;
      w_flags_nxt = r_flags;
      w_page_nxt  = r_page;

      case (r_state)
         S_LOAD_A: begin
            if (w_enter) begin
               w_a_nxt     = w_operand;
               w_state_nxt = S_LOAD_B;
            end else if (w_back) begin
               w_a_nxt = '0;
            end
         end
         S_LOAD_B: begin
            if (w_enter) begin
               w_b_nxt     = w_operand;
               w_state_nxt = S_LOAD_OP;
            end else if (w_back) begin
               w_state_nxt = S_LOAD_A;
            end
         end
         S_LOAD_OP: begin
            if (w_enter) begin
               w_op_nxt    = sw_data[OP_W-1:0];
               w_state_nxt = S_EXEC;
            end else if (w_back) begin
               w_state_nxt = S_LOAD_B;
            end
         end
         S_EXEC: begin
            // ALU output is combinational from the registered ports
            w_res_nxt   = alu_port_o;
            w_flags_nxt = {alu_overflow, alu_zero, alu_negative};
            w_state_nxt = S_SHOW;
         end
         S_SHOW: begin
            if (w_enter) begin
               w_state_nxt = S_LOAD_A;
            end else if (w_back) begin
               w_state_nxt = S_LOAD_OP;
            end
         end
         default: begin
            w_state_nxt = S_LOAD_A;
         end
      endcase

      if (w_state_nxt != r_state) begin
         w_page_nxt = '0;
      end else if (w_page) begin
         w_page_nxt = (r_page == c_PAGE_W'(c_NPAGES - 1)) ? '0
                                                          : r_page + c_PAGE_W'(1);
      end
   end

   // state and datapath registers
   always_ff @(posedge CLOCK_50) begin
      if (RST) begin
         r_state <= S_LOAD_A;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= '0;
         r_res   <= '0;
         r_flags <= '0;
         r_page  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         r_op    <= w_op_nxt;
         r_res   <= w_res_nxt;
         r_flags <= w_flags_nxt;
         r_page  <= w_page_nxt;
      end
   end

   assign alu_port_a = r_a;
   assign alu_port_b = r_b;
   assign alu_op     = r_op;
   assign led_flags  = r_flags;
   assign led_state  = r_state;

   //---------------------------------------------------------------------------
   // Display path
   //---------------------------------------------------------------------------
   // pick what the digits show in each state
   always_comb begin
      case (r_state)
         S_LOAD_A, S_LOAD_B: w_disp_src = w_operand;
         S_LOAD_OP:          w_disp_src = DATA_W'(r_op);
         default:            w_disp_src = r_res;
      endcase
   end

   assign w_disp_ext = c_DISP_W'(w_disp_src);

   // select the current page and blank nibbles that lie past DATA_W
   always_comb begin
      w_page_vec = w_disp_ext[c_PG_BITS-1:0];
      w_blank    = '0;
      for (int p = 0; p < c_NPAGES; p++) begin
         if (r_page == c_PAGE_W'(p)) begin
            w_page_vec = w_disp_ext[p*c_PG_BITS +: c_PG_BITS];
            for (int i = 0; i < NDIGITS; i++) begin
               w_blank[i] = (4 * (p * NDIGITS + i) >= DATA_W);
            end
         end
      end
   end

   for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
      assign hex_seg[7*i +: 7] = w_blank[i] ? 7'b1111111
                                            : f_seg7(w_page_vec[4*i +: 4]);
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_fpga_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_fpga_ctrl
// Brief    : Self-checking bench for alu_fpga_ctrl with a behavioural ALU.
//            Three builds share the board inputs: the default 32-bit/8-digit
//            one, a 4-digit (two page) one and a 20-bit one.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_fpga_ctrl;

   localparam int DB = 16;

   localparam logic [4:0] ST_A    = 5'b00001;
   localparam logic [4:0] ST_B    = 5'b00010;
   localparam logic [4:0] ST_OP   = 5'b00100;
   localparam logic [4:0] ST_EXEC = 5'b01000;
   localparam logic [4:0] ST_SHOW = 5'b10000;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] sw_data;
   logic        sw_fill;
   logic [2:0]  key_n;

   // main build
   logic [31:0] m_a, m_b, m_o;
   logic [3:0]  m_op;
   logic        m_n, m_z, m_v;
   logic [55:0] m_hex;
   logic [2:0]  m_flags;
   logic [4:0]  m_state;

   // four-digit build
   logic [31:0] p_a, p_b, p_o;
   logic [3:0]  p_op;
   logic        p_n, p_z, p_v;
   logic [27:0] p_hex;
   logic [2:0]  p_flags;
   logic [4:0]  p_state;

   // 20-bit build
   logic [19:0] w_a, w_b, w_o;
   logic [3:0]  w_op;
   logic        w_n, w_z, w_v;
   logic [55:0] w_hex;
   logic [2:0]  w_flags;
   logic [4:0]  w_state;
   logic [34:0] w_m;

   int n_vec = 0;
   int n_err = 0;
   logic [34:0] sb_q[$];
   logic [4:0]  prev_state = 5'b00001;

   always #5 clk = ~clk;

   // Behavioural ALU: 3 = add, 4 = {A[15:0], B[15:0]}, others = xor.
   // Returns {overflow, zero, negative, result}.
   function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
      logic [31:0] r;
      logic        v;
      v = 1'b0;
      case (op)
         4'd3: begin
            r = a + b;
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         4'd4:    r = (a << 16) | {16'h0000, b[15:0]};
         default: r = a ^ b;
      endcase
      return {v, (r == 32'h0), r[31], r};
   endfunction

   assign {m_v, m_z, m_n, m_o} = alu_model(m_a, m_b, m_op);
   assign {p_v, p_z, p_n, p_o} = alu_model(p_a, p_b, p_op);
   assign w_m = alu_model({12'h0, w_a}, {12'h0, w_b}, w_op);
   assign w_o = w_m[19:0];
   assign w_n = w_o[19];
   assign w_z = (w_o == 20'h0);
   assign w_v = 1'b0;

   alu_fpga_ctrl #(.DATA_W(32), .SW_W(16), .OP_W(4), .NDIGITS(8), .DB_CYCLES(DB)) u_dut (
      .CLOCK_50(clk), .RST(rst), .sw_data(sw_data), .sw_fill(sw_fill), .key_n(key_n),
      .alu_port_a(m_a), .alu_port_b(m_b), .alu_op(m_op), .alu_port_o(m_o),
      .alu_negative(m_n), .alu_zero(m_z), .alu_overflow(m_v),
      .hex_seg(m_hex), .led_flags(m_flags), .led_state(m_state));

   alu_fpga_ctrl #(.DATA_W(32), .SW_W(16), .OP_W(4), .NDIGITS(4), .DB_CYCLES(DB)) u_pg (
      .CLOCK_50(clk), .RST(rst), .sw_data(sw_data), .sw_fill(sw_fill), .key_n(key_n),
      .alu_port_a(p_a), .alu_port_b(p_b), .alu_op(p_op), .alu_port_o(p_o),
      .alu_negative(p_n), .alu_zero(p_z), .alu_overflow(p_v),
      .hex_seg(p_hex), .led_flags(p_flags), .led_state(p_state));

   alu_fpga_ctrl #(.DATA_W(20), .SW_W(16), .OP_W(4), .NDIGITS(8), .DB_CYCLES(DB)) u_w20 (
      .CLOCK_50(clk), .RST(rst), .sw_data(sw_data), .sw_fill(sw_fill), .key_n(key_n),
      .alu_port_a(w_a), .alu_port_b(w_b), .alu_op(w_op), .alu_port_o(w_o),
      .alu_negative(w_n), .alu_zero(w_z), .alu_overflow(w_v),
      .hex_seg(w_hex), .led_flags(w_flags), .led_state(w_state));

   function automatic logic [6:0] seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
         4'hC: s = 7'b0100111;  4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;  default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   function automatic logic [55:0] exp_hex8(input logic [31:0] v);
      logic [55:0] h;
      for (int i = 0; i < 8; i++) h[7*i +: 7] = seg(v[4*i +: 4]);
      return h;
   endfunction

   function automatic logic [27:0] exp_hex4(input logic [15:0] v);
      logic [27:0] h;
      for (int i = 0; i < 4; i++) h[7*i +: 7] = seg(v[4*i +: 4]);
      return h;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_vec++;
      if (obs !== want) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, want);
      end
   endtask

   // hold the keys in mask long enough to register, then release and settle
   task automatic press(input logic [2:0] mask);
      @(negedge clk);
      key_n = ~mask;
      repeat (DB + 4) @(negedge clk);
      key_n = 3'b111;
      repeat (DB + 4) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // scoreboard: each EXEC->SHOW entry of the main build consumes one expectation
   always @(negedge clk) begin
      logic [34:0] e;
      if (!rst && m_state == ST_SHOW && prev_state == ST_EXEC) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected", 64'(m_state), 64'(prev_state));
         end else begin
            e = sb_q.pop_front();
            chk("sb_hex", 64'(m_hex), 64'(exp_hex8(e[31:0])));
            chk("sb_flags", 64'(m_flags), 64'(e[34:32]));
         end
      end
      prev_state = m_state;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [55:0] w20_exp;
      rst     = 1'b1;
      key_n   = 3'b111;
      sw_data = 16'h0000;
      sw_fill = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // reset state
      chk("rst_state", 64'(m_state), 64'(ST_A));
      chk("rst_a", 64'(m_a), 64'h0);
      chk("rst_b", 64'(m_b), 64'h0);
      chk("rst_op", 64'(m_op), 64'h0);
      chk("rst_flags", 64'(m_flags), 64'h0);
      chk("rst_hex", 64'(m_hex), 64'(exp_hex8(32'h0)));
      chk("w20_rst_blank", 64'(w_hex[55:35]), 64'h1FFFFF);

      // debounce latency: state moves on the edge after the pulse cycle
      @(negedge clk);
      key_n[0] = 1'b0;
      for (int e = 1; e <= DB + 5; e++) begin
         @(posedge clk);
         #1;
         if (e == DB + 2) chk("db_before", 64'(m_state), 64'(ST_A));
         if (e == DB + 3) chk("db_after", 64'(m_state), 64'(ST_B));
      end
      chk("db_single", 64'(m_state), 64'(ST_B));
      @(negedge clk);
      key_n = 3'b111;
      repeat (DB + 4) @(negedge clk);
      // 10-cycle glitch is rejected
      key_n[0] = 1'b0;
      repeat (10) @(negedge clk);
      key_n = 3'b111;
      repeat (DB + 10) @(negedge clk);
      chk("glitch", 64'(m_state), 64'(ST_B));

      // operand entry and execute
      do_reset();
      sw_data = 16'h8001; sw_fill = 1'b1;
      press(3'b001);
      chk("load_a", 64'(m_a), 64'hFFFF8001);
      chk("st_b", 64'(m_state), 64'(ST_B));
      sw_data = 16'h0002; sw_fill = 1'b0;
      press(3'b001);
      chk("load_b", 64'(m_b), 64'h00000002);
      chk("st_op", 64'(m_state), 64'(ST_OP));
      sw_data = 16'h0003;
      sb_q.push_back({3'b001, 32'hFFFF8003});
      press(3'b001);
      chk("st_show", 64'(m_state), 64'(ST_SHOW));
      chk("op_reg", 64'(m_op), 64'h3);
      chk("dig0", 64'(m_hex[6:0]), 64'(7'b0110000));
      chk("dig7", 64'(m_hex[55:49]), 64'(7'b0001110));

      // back navigation
      press(3'b010);
      chk("show_back", 64'(m_state), 64'(ST_OP));
      chk("show_back_op", 64'(m_op), 64'h3);
      press(3'b010);
      chk("op_back", 64'(m_state), 64'(ST_B));
      chk("op_back_a", 64'(m_a), 64'hFFFF8001);
      press(3'b010);
      chk("b_back", 64'(m_state), 64'(ST_A));
      press(3'b010);
      chk("a_back_clr", 64'(m_a), 64'h0);
      chk("a_back_st", 64'(m_state), 64'(ST_A));

      // simultaneous pulses
      sw_data = 16'h5678;
      press(3'b110);
      chk("bp_a", 64'(m_a), 64'h0);
      chk("bp_st", 64'(m_state), 64'(ST_A));
      chk("bp_pg_page0", 64'(p_hex), 64'(exp_hex4(16'h5678)));
      sw_data = 16'h1234;
      press(3'b101);
      chk("ep_a", 64'(m_a), 64'h00001234);
      chk("ep_st", 64'(m_state), 64'(ST_B));
      chk("ep_pg_page0", 64'(p_hex), 64'(exp_hex4(16'h1234)));

      // paging on the result
      sw_data = 16'h5678;
      press(3'b001);
      chk("pg_load_b", 64'(m_b), 64'h00005678);
      sw_data = 16'h0004;
      sb_q.push_back({3'b000, 32'h12345678});
      press(3'b001);
      chk("pg_show", 64'(m_state), 64'(ST_SHOW));
      chk("pg_p0", 64'(p_hex), 64'(exp_hex4(16'h5678)));
      w20_exp = exp_hex8(32'h00045678);
      w20_exp[55:35] = '1;
      chk("w20_hex", 64'(w_hex), 64'(w20_exp));
      press(3'b100);
      chk("pg_p1", 64'(p_hex), 64'(exp_hex4(16'h1234)));
      chk("pg_main", 64'(m_hex), 64'(exp_hex8(32'h12345678)));
      press(3'b100);
      chk("pg_wrap", 64'(p_hex), 64'(exp_hex4(16'h5678)));

      // enter from SHOW keeps the registers
      press(3'b001);
      chk("ret_st", 64'(m_state), 64'(ST_A));
      chk("ret_a", 64'(m_a), 64'h00001234);
      chk("ret_b", 64'(m_b), 64'h00005678);
      chk("ret_op", 64'(m_op), 64'h4);
      sw_data = 16'h0001;
      press(3'b001);
      press(3'b001);
      chk("rx_st_op", 64'(m_state), 64'(ST_OP));

      // reset during EXEC
      sw_data = 16'hABCD; sw_fill = 1'b1;
      @(negedge clk);
      key_n = 3'b110;
      for (int t = 0; t < DB + 10 && m_state != ST_EXEC; t++) @(negedge clk);
      chk("exec_seen", 64'(m_state), 64'(ST_EXEC));
      rst   = 1'b1;
      key_n = 3'b111;
      @(negedge clk);
      rst = 1'b0;
      chk("rx_state", 64'(m_state), 64'(ST_A));
      chk("rx_a", 64'(m_a), 64'h0);
      chk("rx_b", 64'(m_b), 64'h0);
      chk("rx_op", 64'(m_op), 64'h0);
      chk("rx_flags", 64'(m_flags), 64'h0);
      chk("rx_hex", 64'(m_hex), 64'(exp_hex8(32'hFFFFABCD)));
      repeat (DB + 6) @(negedge clk);
      chk("rx_stay", 64'(m_state), 64'(ST_A));

      chk("sb_drained", 64'(sb_q.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
